// File: rtl/alu_arb_if.sv
// alu_arb_if
//   Bundles the signals between the protocol engines, the alu_arb sequencer
//   and the shared modular ALU.
//   Requester side : req_val/req_rdy handshake with per-requester op, field
//                    select and operand slices; one-hot rsp_val pulse with
//                    rsp_res/rsp_bad/rsp_tmo.
//   ALU side       : alu_run launch pulse, latched alu_op/alu_fld/alu_opa/
//                    alu_opb, alu_clr abort pulse; alu_res/alu_done/alu_bad
//                    returned by the ALU.
//   busy           : sequencer has an operation in progress.
//   Modports: slave  = the arbiter itself,
//             master = everything around it (requesters plus the ALU).
interface alu_arb_if #(
  parameter int N_REQ = 4,
  parameter int W     = 256
);
  logic [N_REQ-1:0]   req_val;
  logic [N_REQ-1:0]   req_rdy;
  logic [2*N_REQ-1:0] req_op;
  logic [N_REQ-1:0]   req_fld;
  logic [W*N_REQ-1:0] req_opa;
  logic [W*N_REQ-1:0] req_opb;

  logic [N_REQ-1:0]   rsp_val;
  logic [W-1:0]       rsp_res;
  logic               rsp_bad;
  logic               rsp_tmo;

  logic               alu_run;
  logic [1:0]         alu_op;
  logic               alu_fld;
  logic [W-1:0]       alu_opa;
  logic [W-1:0]       alu_opb;
  logic               alu_clr;
  logic [W-1:0]       alu_res;
  logic               alu_done;
  logic               alu_bad;

  logic               busy;

  modport slave (
    input  req_val, req_op, req_fld, req_opa, req_opb,
    input  alu_res, alu_done, alu_bad,
    output req_rdy, rsp_val, rsp_res, rsp_bad, rsp_tmo,
    output alu_run, alu_op, alu_fld, alu_opa, alu_opb, alu_clr,
    output busy
  );

  modport master (
    output req_val, req_op, req_fld, req_opa, req_opb,
    output alu_res, alu_done, alu_bad,
    input  req_rdy, rsp_val, rsp_res, rsp_bad, rsp_tmo,
    input  alu_run, alu_op, alu_fld, alu_opa, alu_opb, alu_clr,
    input  busy
  );
endinterface

// File: rtl/alu_arb.sv
// alu_arb
//   Round-robin arbiter and sequencer in front of one shared modular ALU.
//   One operation is in flight at a time: IDLE accepts a request, ISSUE
//   pulses alu_run, WAIT waits for alu_done (or the watchdog), RESP returns
//   a one-cycle one-hot response to the owner and advances the pointer.
// Ports
//   clk  : system clock
//   rst  : asynchronous active-high reset, aborts any operation
//   bus  : alu_arb_if slave modport (requests, responses, ALU control)
// Parameters
//   N_REQ   : number of requesters (2..8)
//   W       : operand/result width
//   TMO_CYC : WAIT cycles allowed before the operation is aborted (>= 2)
module alu_arb #(
  parameter int N_REQ   = 4,
  parameter int W       = 256,
  parameter int TMO_CYC = 4096
) (
  input logic      clk,
  input logic      rst,
  alu_arb_if.slave bus
);
  localparam int PW   = $clog2(N_REQ);
  localparam int SUMW = PW + 1;
  localparam int TW   = $clog2(TMO_CYC);

  localparam logic [PW-1:0]    LAST_IDX = PW'(N_REQ - 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [1:0]     op_q, op_d;
  logic           fld_q, fld_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   res_q, res_d;
  logic           bad_q, bad_d;
  logic           tmo_q, tmo_d;

  logic [N_REQ-1:0] rdy_c;
  logic             clr_c;

  // Per-requester views of the flattened request buses.
  logic [1:0]   slot_op  [N_REQ];
  logic [W-1:0] slot_opa [N_REQ];
  logic [W-1:0] slot_opb [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign slot_op[gi]  = bus.req_op[2*gi +: 2];
      assign slot_opa[gi] = bus.req_opa[W*gi +: W];
      assign slot_opb[gi] = bus.req_opb[W*gi +: W];
    end
  endgenerate

  // Round-robin search: rotate req_val so that bit 0 is the requester at
  // ptr, take the lowest set bit, then map the offset back to an index.
  logic [2*N_REQ-1:0] val_dbl;
  logic [2*N_REQ-1:0] val_rot;
  logic               win_found;
  logic [PW-1:0]      win_off;
  logic [SUMW-1:0]    win_sum;
  logic [PW-1:0]      win_idx;

  assign val_dbl = {bus.req_val, bus.req_val};
  assign val_rot = val_dbl >> ptr_q;

  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    // Descending scan so the lowest offset is the last (winning) write.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (val_rot[k]) begin
        win_found = 1'b1;
        win_off   = PW'(k);
      end
    end
    win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    if (win_sum >= SUMW'(N_REQ)) begin
      win_sum = win_sum - SUMW'(N_REQ);
    end
    win_idx = win_sum[PW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      timer_q <= '0;
      op_q    <= '0;
      fld_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      bad_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      op_q    <= op_d;
      fld_q   <= fld_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      bad_q   <= bad_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    timer_d = timer_q;
    op_d    = op_q;
    fld_d   = fld_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    bad_d   = bad_q;
    tmo_d   = tmo_q;
    rdy_c   = '0;
    clr_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          rdy_c   = ONE_HOT0 << win_idx;
          owner_d = win_idx;
          op_d    = slot_op[win_idx];
          fld_d   = bus.req_fld[win_idx];
          opa_d   = slot_opa[win_idx];
          opb_d   = slot_opb[win_idx];
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // A done in the same cycle as the timeout still counts as done.
        if (bus.alu_done) begin
          res_d   = bus.alu_res;
          bad_d   = bus.alu_bad;
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timer_q == TMO_LAST) begin
          clr_c   = 1'b1;
          res_d   = '0;
          bad_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_RESP: begin
        ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // req_rdy is combinational from req_val; mask it while reset is held so
  // every output reads 0 during reset.
  assign bus.req_rdy = rst ? '0 : rdy_c;
  assign bus.rsp_val = (state_q == ST_RESP) ? (ONE_HOT0 << owner_q) : '0;
  assign bus.rsp_res = res_q;
  assign bus.rsp_bad = (state_q == ST_RESP) & bad_q;
  assign bus.rsp_tmo = (state_q == ST_RESP) & tmo_q;
  assign bus.alu_run = (state_q == ST_ISSUE);
  assign bus.alu_op  = op_q;
  assign bus.alu_fld = fld_q;
  assign bus.alu_opa = opa_q;
  assign bus.alu_opb = opb_q;
  assign bus.alu_clr = clr_c;
  assign bus.busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb
//   Directed bench for alu_arb with a scoreboard. Stimulus pushes expected
//   responses (and expected ALU launches) into queues; a monitor pops and
//   compares whenever rsp_val pulses, and the ALU model checks each launch.
module tb_alu_arb;
  localparam int N   = 4;
  localparam int W   = 256;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arb_if #(.N_REQ(N), .W(W)) bus ();

  alu_arb #(.N_REQ(N), .W(W), .TMO_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           owner;
    logic [W-1:0] res;
    bit           bad;
    bit           tmo;
  } rsp_t;

  typedef struct {
    logic [1:0] op;
    logic       fld;
  } iss_t;

  rsp_t exp_q[$];
  iss_t iss_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- requester driver ----------------
  logic [N-1:0] pend     = '0;
  logic [N-1:0] cont     = '0;
  logic [N-1:0] acc      = '0;
  logic [N-1:0] new_mask = '0;
  int           new_seq  = 0;
  int           acc_count = 0;
  int           acc_cyc   = 0;
  int           grant_log[$];
  int           acc_cyc_log[$];
  bit           idle_win = 1'b0;
  int           idle_cnt = 0;

  initial begin : driver
    int seen;
    int idx;
    seen = 0;
    bus.req_val = '0;
    forever begin
      @(negedge clk);
      pend = pend & ~acc;
      if (new_seq != seen) begin
        pend = pend | new_mask;
        seen = new_seq;
      end
      bus.req_val = pend | cont;
      #1;
      acc = bus.req_val & bus.req_rdy;
      if (idle_win && !bus.busy) idle_cnt++;
      if (acc != '0) begin
        check("rdy_onehot", $countones(acc), 1);
        idx = 0;
        for (int k = 0; k < N; k++) if (acc[k]) idx = k;
        grant_log.push_back(idx);
        acc_cyc_log.push_back(cyc);
        acc_cyc = cyc;
        acc_count++;
      end
    end
  end

  // ---------------- ALU model ----------------
  int  lat      = 1;
  bit  hang     = 1'b0;
  int  late_seq = 0;
  int  run_cyc  = 0;
  int  done_cyc = 0;

  initial begin : alu_model
    int           cnt;
    int           late_seen;
    logic [W-1:0] nxt_res;
    bit           nxt_bad;
    iss_t         e;
    cnt = 0;
    late_seen = 0;
    nxt_res = '0;
    nxt_bad = 1'b0;
    bus.alu_done = 1'b0;
    bus.alu_res  = '0;
    bus.alu_bad  = 1'b0;
    forever begin
      @(negedge clk);
      bus.alu_done = 1'b0;
      bus.alu_bad  = 1'b0;
      if (rst) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.alu_done = 1'b1;
          bus.alu_res  = nxt_res;
          bus.alu_bad  = nxt_bad;
          done_cyc     = cyc;
        end
      end
      if (late_seq != late_seen) begin
        late_seen    = late_seq;
        bus.alu_done = 1'b1;
        bus.alu_res  = 256'h5A5A;
        bus.alu_bad  = 1'b0;
      end
      if (bus.alu_run) begin
        run_cyc = cyc;
        if (iss_q.size() == 0) begin
          check("run_unexpected", 1, 0);
        end else begin
          e = iss_q.pop_front();
          check("alu_op", bus.alu_op, e.op);
          check("alu_fld", bus.alu_fld, e.fld);
        end
        nxt_bad = 1'b0;
        case (bus.alu_op)
          2'd0: nxt_res = bus.alu_opa + bus.alu_opb;
          2'd1: nxt_res = bus.alu_opa - bus.alu_opb;
          2'd2: nxt_res = bus.alu_opa * bus.alu_opb;
          default: begin
            if (bus.alu_opa == '0) begin
              nxt_res = 256'hDEAD;
              nxt_bad = 1'b1;
            end else begin
              nxt_res = 256'h1;
            end
          end
        endcase
        cnt = hang ? 0 : lat;
      end
    end
  end

  // ---------------- response monitor ----------------
  int rsp_cnt = 0;
  int rsp_cyc = 0;
  int clr_cnt = 0;
  int clr_cyc = 0;

  initial begin : monitor
    rsp_t         e;
    logic [N-1:0] ev;
    forever begin
      @(negedge clk);
      #3;
      if (bus.alu_clr) begin
        clr_cnt++;
        clr_cyc = cyc;
      end
      if (bus.rsp_val != '0) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_val, 0);
        end else begin
          e  = exp_q.pop_front();
          ev = N'(1) << e.owner;
          check("rsp_val", bus.rsp_val, ev);
          check("rsp_res", bus.rsp_res, e.res);
          check("rsp_bad", bus.rsp_bad, e.bad);
          check("rsp_tmo", bus.rsp_tmo, e.tmo);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic set_slot(input int i, input logic [1:0] op, input logic fld,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_op[2*i +: 2]  = op;
    bus.req_fld[i]        = fld;
    bus.req_opa[W*i +: W] = a;
    bus.req_opb[W*i +: W] = b;
  endtask

  task automatic expect_op(input int owner, input logic [1:0] op, input logic fld,
                           input logic [W-1:0] res, input bit bad, input bit tmo);
    rsp_t r;
    iss_t s;
    r.owner = owner; r.res = res; r.bad = bad; r.tmo = tmo;
    s.op = op; s.fld = fld;
    exp_q.push_back(r);
    iss_q.push_back(s);
  endtask

  task automatic expect_run(input logic [1:0] op, input logic fld);
    iss_t s;
    s.op = op; s.fld = fld;
    iss_q.push_back(s);
  endtask

  task automatic issue(input logic [N-1:0] m);
    new_mask = m;
    new_seq++;
  endtask

  task automatic wait_rsp(input int target, input string name);
    int t;
    t = 0;
    while (rsp_cnt < target && t < 2000) begin
      @(negedge clk);
      #4;
      t++;
    end
    check(name, rsp_cnt, target);
  endtask

  task automatic wait_acc(input int target, input string name);
    int t;
    t = 0;
    while (acc_count < target && t < 2000) begin
      @(negedge clk);
      #4;
      t++;
    end
    check(name, acc_count, target);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int r0;
    int c0;
    int k0;
    rst = 1'b1;
    bus.req_op  = '0;
    bus.req_fld = '0;
    bus.req_opa = '0;
    bus.req_opb = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #4;
    check("rst_req_rdy", bus.req_rdy, 0);
    check("rst_rsp_val", bus.rsp_val, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_alu_run", bus.alu_run, 0);
    check("rst_alu_clr", bus.alu_clr, 0);
    check("rst_rsp_res", bus.rsp_res, 0);
    check("rst_alu_opa", bus.alu_opa, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Fairness: all four continuously valid for eight operations
    lat = 2;
    for (int i = 0; i < N; i++) set_slot(i, 2'd0, 1'b1, 256'(i + 1), 256'd10);
    for (int j = 0; j < 8; j++) expect_op(j % N, 2'd0, 1'b1, 256'(11 + (j % N)), 1'b0, 1'b0);
    grant_log.delete();
    acc_cyc_log.delete();
    r0 = rsp_cnt;
    idle_win = 1'b1;
    cont = '1;
    wait_acc(8, "fair_accepts");
    cont = '0;
    idle_win = 1'b0;
    wait_rsp(r0 + 8, "fair_rsp_count");
    for (int j = 0; j < 8; j++) check("fair_grant", grant_log[j], j % N);
    check("fair_idle_cycles", idle_cnt, 8);
    check("fair_accept_gap", acc_cyc_log[7] - acc_cyc_log[6], lat + 3);

    // Requesters 1 and 2 together, ptr at 0
    lat = 3;
    set_slot(1, 2'd1, 1'b0, 256'd20, 256'd5);
    set_slot(2, 2'd2, 1'b1, 256'd6, 256'd7);
    expect_op(1, 2'd1, 1'b0, 256'd15, 1'b0, 1'b0);
    expect_op(2, 2'd2, 1'b1, 256'd42, 1'b0, 1'b0);
    grant_log.delete();
    r0 = rsp_cnt;
    issue(4'b0110);
    wait_rsp(r0 + 2, "pair12_rsp_count");
    check("pair12_first", grant_log[0], 1);
    check("pair12_second", grant_log[1], 2);

    // Requesters 0 and 3 together: ptr left at 3, so 3 wins first
    set_slot(3, 2'd0, 1'b0, 256'd100, 256'd1);
    set_slot(0, 2'd1, 1'b1, 256'd50, 256'd8);
    expect_op(3, 2'd0, 1'b0, 256'd101, 1'b0, 1'b0);
    expect_op(0, 2'd1, 1'b1, 256'd42, 1'b0, 1'b0);
    grant_log.delete();
    r0 = rsp_cnt;
    issue(4'b1001);
    wait_rsp(r0 + 2, "pair30_rsp_count");
    check("pair30_first", grant_log[0], 3);
    check("pair30_second", grant_log[1], 0);

    // Single add on requester 0 with ten-cycle ALU latency
    lat = 10;
    set_slot(0, 2'd0, 1'b1, 256'd5, 256'd7);
    expect_op(0, 2'd0, 1'b1, 256'd12, 1'b0, 1'b0);
    grant_log.delete();
    r0 = rsp_cnt;
    issue(4'b0001);
    wait_rsp(r0 + 1, "add_rsp_count");
    check("add_grant", grant_log[0], 0);
    check("add_run_latency", run_cyc - acc_cyc, 1);
    check("add_done_latency", done_cyc - run_cyc, 10);
    check("add_rsp_latency", rsp_cyc - done_cyc, 1);
    @(negedge clk);
    #4;
    check("add_opa_held", bus.alu_opa, 5);
    check("add_opb_held", bus.alu_opb, 7);
    check("add_res_held", bus.rsp_res, 12);

    // inv of zero flagged bad by the ALU
    lat = 4;
    set_slot(2, 2'd3, 1'b1, 256'd0, 256'd123);
    expect_op(2, 2'd3, 1'b1, 256'hDEAD, 1'b1, 1'b0);
    grant_log.delete();
    r0 = rsp_cnt;
    issue(4'b0100);
    wait_rsp(r0 + 1, "inv_rsp_count");
    check("inv_grant", grant_log[0], 2);

    // Reset in the middle of WAIT with requests 0 and 3 pending
    hang = 1'b1;
    set_slot(1, 2'd0, 1'b1, 256'd3, 256'd4);
    expect_run(2'd0, 1'b1);
    grant_log.delete();
    k0 = acc_count;
    issue(4'b0010);
    wait_acc(k0 + 1, "rstw_accept");
    check("rstw_grant", grant_log[0], 1);
    repeat (4) @(negedge clk);
    set_slot(0, 2'd0, 1'b1, 256'd1, 256'd2);
    set_slot(3, 2'd2, 1'b0, 256'd3, 256'd5);
    issue(4'b1001);
    repeat (2) @(negedge clk);
    check("rstw_busy_before", bus.busy, 1);
    r0 = rsp_cnt;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rstw_req_rdy", bus.req_rdy, 0);
    check("rstw_rsp_val", bus.rsp_val, 0);
    check("rstw_busy", bus.busy, 0);
    check("rstw_alu_run", bus.alu_run, 0);
    check("rstw_alu_clr", bus.alu_clr, 0);
    check("rstw_alu_op", bus.alu_op, 0);
    check("rstw_alu_opa", bus.alu_opa, 0);
    check("rstw_rsp_res", bus.rsp_res, 0);
    hang = 1'b0;
    lat = 2;
    expect_op(0, 2'd0, 1'b1, 256'd3, 1'b0, 1'b0);
    expect_op(3, 2'd2, 1'b0, 256'd15, 1'b0, 1'b0);
    grant_log.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_rsp(r0 + 2, "rstw_rsp_count");
    check("rstw_first", grant_log[0], 0);
    check("rstw_second", grant_log[1], 3);

    // Watchdog timeout, then a late done, then a normal operation
    hang = 1'b1;
    set_slot(1, 2'd0, 1'b1, 256'd3, 256'd4);
    expect_op(1, 2'd0, 1'b1, 256'd0, 1'b1, 1'b1);
    grant_log.delete();
    c0 = clr_cnt;
    r0 = rsp_cnt;
    issue(4'b0010);
    wait_rsp(r0 + 1, "tmo_rsp_count");
    check("tmo_grant", grant_log[0], 1);
    check("tmo_clr_count", clr_cnt - c0, 1);
    check("tmo_clr_latency", clr_cyc - acc_cyc, TMO + 1);
    check("tmo_rsp_latency", rsp_cyc - clr_cyc, 1);
    repeat (4) @(negedge clk);
    late_seq++;
    repeat (6) @(negedge clk);
    #4;
    check("late_no_rsp", rsp_cnt, r0 + 1);
    check("late_not_busy", bus.busy, 0);
    check("late_no_clr", clr_cnt - c0, 1);
    hang = 1'b0;
    lat = 3;
    set_slot(3, 2'd2, 1'b1, 256'd3, 256'd3);
    expect_op(3, 2'd2, 1'b1, 256'd9, 1'b0, 1'b0);
    grant_log.delete();
    issue(4'b1000);
    wait_rsp(r0 + 2, "after_tmo_rsp_count");
    check("after_tmo_grant", grant_log[0], 3);
    check("exp_queue_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arb.md
# alu_arb

Round-robin arbiter and sequencer that shares one modular ALU (256-bit add/sub/mul/inv over the Curve25519 field or the alternate field) between up to N_REQ requesters. It accepts one operation at a time through a valid/ready handshake, launches the ALU with a single-cycle run pulse and waits for done. It returns the result to the owning requester as a one-cycle response, and a watchdog aborts hung operations. It sits between the protocol engines and the shared ALU instance.

## Interface
- N_REQ, 4: number of requesters (2..8).
- W, 256: operand/result width.
- TMO_CYC, 4096: max cycles in WAIT before abort (≥2).
- clk in 1: system clock.
- rst in 1: asynchronous, active-high reset.
- req_val in N_REQ: per-requester request valid; held until accepted.
- req_rdy out N_REQ: one-hot accept; handshake completes when val&rdy.
- req_op in 2*N_REQ: per-requester op, slice i = [2i+1:2i]; 0 add, 1 sub, 2 mul, 3 inv.
- req_fld in N_REQ: 1 = Curve25519 field, 0 = alternate field.
- req_opa in W*N_REQ: operand A, slice i = [W*i+W-1:W*i].
- req_opb in W*N_REQ: operand B, same slicing; ignored for inv.
- rsp_val out N_REQ: one-hot, one-cycle response pulse to owner.
- rsp_res out W: result, valid with rsp_val.
- rsp_bad out 1: ALU flagged bad operand, or timeout.
- rsp_tmo out 1: timeout abort; implies rsp_bad.
- alu_run out 1: one-cycle launch pulse.
- alu_op out 2: latched op.
- alu_fld out 1: latched field select.
- alu_opa, alu_opb out W each: latched operands.
- alu_clr out 1: one-cycle pulse on timeout; OR'd into ALU reset externally.
- alu_res in W: ALU result, valid with alu_done.
- alu_done in 1: ALU completion pulse.
- alu_bad in 1: ALU bad-operand flag, sampled with alu_done.
- busy out 1: state ≠ IDLE.

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: if any req_val, winner = first set bit searching from ptr upward with wrap. req_rdy[winner] = 1 combinationally in that cycle. Latch op/fld/opa/opb and owner. Go to ISSUE. If no req_val, stay.
- ISSUE: alu_run = 1 for exactly one cycle. Clear timer. Go to WAIT.
- WAIT: on alu_done, latch alu_res into rsp_res and alu_bad into the bad flag, then go to RESP. Otherwise timer increments. When timer = TMO_CYC-1 without done: pulse alu_clr, set bad = tmo = 1, force the result to 0, then go to RESP.
- RESP: rsp_val[owner] = 1, rsp_bad, rsp_tmo driven. ptr ← (owner+1) mod N_REQ. Go to IDLE.
- req_rdy is 0 outside IDLE. Requests arriving while busy wait.
- alu_done outside WAIT is ignored, including a done in the ISSUE cycle or a late done after a timeout.
- alu_op/fld/opa/opb hold their latched values from acceptance until the next acceptance.
- rsp_res holds its value until the next RESP.

## Timing
- Reset (async assert, sync deassert handled upstream): state IDLE, ptr 0, timer 0, all outputs 0.
- Reset during any state aborts immediately. No response is issued. The ALU is reset by the same rst.
- Latency from handshake cycle (T) with ALU done at cycle D ≥ T+2:
  - alu_run at T+1;
  - rsp_val at D+1;
  - next accept earliest at D+2.
- Overhead is 3 cycles plus ALU latency per operation. No pipelining; one operation in flight.
- Timeout: the first WAIT cycle is T+2. alu_clr and the transition to RESP occur in the cycle where timer reaches TMO_CYC-1. rsp_val with rsp_tmo follows one cycle later.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 operations.

## Test plan
- Single add, requester 0, fld=1, opa=5, opb=7, ALU done 10 cycles after run → req_rdy[0] at T, alu_run at T+1, rsp_val[0] with rsp_res=12, rsp_bad=0.
- Requesters 1 and 2 assert in the same cycle with ptr=0 → 1 granted first, then 2. ptr ends at 3. Each gets its own one-hot rsp_val.
- All 4 continuously valid for 8 operations → grant order 0,1,2,3,0,1,2,3. busy stays 1 except one IDLE cycle between operations.
- inv with opa=0, ALU returns alu_bad=1 → rsp_bad=1, rsp_tmo=0, response to the correct owner.
- ALU never asserts done, TMO_CYC=16 → alu_clr pulse once, rsp_bad=rsp_tmo=1, rsp_res=0. A late alu_done 5 cycles later is ignored, and the next request is served normally.
- rst asserted mid-WAIT → all outputs 0 asynchronously, no rsp_val. After release the pending req_val is granted from ptr 0.
